// File: rtl/alarm_controller.sv
// Alarm clock sequencer: owns the shared time comparator, alarm/snooze state.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MINUTES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] time_now,
  input  logic        min_tick,
  input  logic [12:0] alarm_in,
  input  logic        alarm_load,
  input  logic        arm,
  input  logic        snooze,
  input  logic        stop,
  output logic [12:0] cmp_a,
  output logic [12:0] cmp_b,
  input  logic        cmp_eq,
  output logic [12:0] alarm_time,
  output logic        armed,
  output logic        ringing,
  output logic        snoozing
);

  localparam logic [3:0] LP_LAST = 4'(RING_MINUTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RINGING,
    S_SNOOZE
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [12:0] r_alarm;
  logic [3:0]  r_cnt;
  logic        r_match;
  logic        w_hit;

  assign w_hit      = cmp_eq & ~r_match;
  assign cmp_a      = time_now;
  assign alarm_time = r_alarm;

`ifdef ALARM_SNOOZE_EN
  logic [12:0] r_snz;
  logic        r_snoozing;

  // BCD HH:MM plus SNOOZE_MIN minutes, wrapping 23:59 -> 00:00
  function automatic logic [12:0] f_add(input logic [12:0] t);
    logic [6:0] m;
    logic [6:0] h;
    m = 7'(t[6:4]) * 7'd10 + 7'(t[3:0]);
    h = 7'(t[12:11]) * 7'd10 + 7'(t[10:7]);
    m = m + 7'(SNOOZE_MIN);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = (h == 7'd23) ? 7'd0 : h + 7'd1;
    end
    f_add = {2'(h / 7'd10), 4'(h % 7'd10),
             3'(m / 7'd10), 4'(m % 7'd10)};
  endfunction

  assign cmp_b    = (r_state == S_SNOOZE) ? r_snz : r_alarm;
  assign snoozing = r_snoozing;
`else
  logic w_unused;
  assign w_unused = snooze;
  assign cmp_b    = r_alarm;
  assign snoozing = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    if (!arm) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_nxt = S_ARMED;
        S_ARMED: if (w_hit) w_nxt = S_RINGING;
        S_RINGING: begin
          if (alarm_load || stop)
            w_nxt = S_ARMED;
`ifdef ALARM_SNOOZE_EN
          else if (snooze)
            w_nxt = S_SNOOZE;
`endif
          else if (min_tick && r_cnt == LP_LAST)
            w_nxt = S_ARMED;
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (alarm_load || stop)
            w_nxt = S_ARMED;
          else if (w_hit)
            w_nxt = S_RINGING;
        end
`endif
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_alarm <= '0;
      r_cnt   <= '0;
      r_match <= 1'b1;
      armed   <= 1'b0;
      ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz      <= '0;
      r_snoozing <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      // suppress a match already in progress when the context changes
      r_match <= (w_nxt != r_state || alarm_load) ? 1'b1 : cmp_eq;
      if (alarm_load)
        r_alarm <= alarm_in;
      if (w_nxt == S_RINGING && r_state != S_RINGING)
        r_cnt <= '0;
      else if (r_state == S_RINGING && min_tick)
        r_cnt <= r_cnt + 4'd1;
      armed   <= (w_nxt == S_ARMED);
      ringing <= (w_nxt == S_RINGING);
`ifdef ALARM_SNOOZE_EN
      if (r_state == S_RINGING && w_nxt == S_SNOOZE)
        r_snz <= f_add(time_now);
      r_snoozing <= (w_nxt == S_SNOOZE);
`endif
    end
  end

endmodule
